// File: rtl/tm1638_scroll_display.sv
// Scrolling hex-message window with 7-seg encoding and 8-key debounce (optional key stepping: TM1638_SCROLL_KEYCTL_EN).
// Latency: digit_out 1 cycle, key events 2+DEBOUNCE_CYCLES cycles; no backpressure, outputs are always valid.
module tm1638_scroll_display #(
   parameter int NUM_DIGITS      = 8,
   parameter int MSG_NIBBLES     = 16,
   parameter int SCROLL_DIV      = 250000,
   parameter int DEBOUNCE_CYCLES = 10000,
   localparam int WPW            = (MSG_NIBBLES > 1) ? $clog2(MSG_NIBBLES) : 1
) (
   input  logic                    clk_1MHz,
   input  logic                    rst,
   input  logic [4*MSG_NIBBLES-1:0] msg_value,
   input  logic                    msg_load,
   input  logic                    scroll_en,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   dots,
   input  logic [7:0]              raw_keys,
   output logic [8*NUM_DIGITS-1:0] digit_out,
   output logic [WPW-1:0]          window_pos,
   output logic [7:0]              key_state,
   output logic [7:0]              key_pressed,
   output logic [7:0]              key_released
);

   localparam int PSW = $clog2(SCROLL_DIV);
   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int IXW = WPW + 1;

   localparam logic [PSW-1:0] PS_LAST = PSW'(SCROLL_DIV - 1);
   localparam logic [WPW-1:0] WP_LAST = WPW'(MSG_NIBBLES - 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   function automatic logic [6:0] hex_glyph(input logic [3:0] n);
      case (n)
         4'h0: hex_glyph = 7'h3F;
         4'h1: hex_glyph = 7'h06;
         4'h2: hex_glyph = 7'h5B;
         4'h3: hex_glyph = 7'h4F;
         4'h4: hex_glyph = 7'h66;
         4'h5: hex_glyph = 7'h6D;
         4'h6: hex_glyph = 7'h7D;
         4'h7: hex_glyph = 7'h07;
         4'h8: hex_glyph = 7'h7F;
         4'h9: hex_glyph = 7'h6F;
         4'hA: hex_glyph = 7'h77;
         4'hB: hex_glyph = 7'h7C;
         4'hC: hex_glyph = 7'h39;
         4'hD: hex_glyph = 7'h5E;
         4'hE: hex_glyph = 7'h79;
         default: hex_glyph = 7'h71;
      endcase
   endfunction

   logic [4*MSG_NIBBLES-1:0] shadow;
   logic [PSW-1:0]           prescaler;
   logic [WPW-1:0]           wp_inc;

   assign wp_inc = (window_pos == WP_LAST) ? '0 : window_pos + 1'b1;

`ifdef TM1638_SCROLL_KEYCTL_EN
   logic [WPW-1:0] wp_dec;
   assign wp_dec = (window_pos == '0) ? WP_LAST : window_pos - 1'b1;
`endif

   // Load wins over a scroll step; manual key stepping only applies while scrolling is paused.
   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         shadow     <= '0;
         window_pos <= '0;
         prescaler  <= '0;
      end else if (msg_load) begin
         shadow     <= msg_value;
         window_pos <= '0;
         prescaler  <= '0;
      end else if (scroll_en) begin
         if (prescaler == PS_LAST) begin
            prescaler  <= '0;
            window_pos <= wp_inc;
         end else begin
            prescaler <= prescaler + 1'b1;
         end
      end
`ifdef TM1638_SCROLL_KEYCTL_EN
      else if (key_pressed[0] && !key_pressed[1]) begin
         window_pos <= wp_inc;
      end else if (key_pressed[1] && !key_pressed[0]) begin
         window_pos <= wp_dec;
      end
`endif
   end

   logic [3:0]              msg_nib [MSG_NIBBLES];
   logic [8*NUM_DIGITS-1:0] digit_nxt;
   logic [IXW-1:0]          idx;
   logic [3:0]              nib;
   logic [6:0]              seg;
   logic                    lead;

   always_comb begin
      for (int p = 0; p < MSG_NIBBLES; p++) begin
         msg_nib[p] = shadow[4*(MSG_NIBBLES-1-p) +: 4];
      end
   end

   // Window start plus digit offset never exceeds two message lengths, so one wrap subtraction suffices.
   always_comb begin
      digit_nxt = '0;
      idx       = '0;
      nib       = '0;
      seg       = '0;
      lead      = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         idx = {1'b0, window_pos} + IXW'(i);
         if (idx >= IXW'(MSG_NIBBLES)) begin
            idx = idx - IXW'(MSG_NIBBLES);
         end
         nib = msg_nib[idx[WPW-1:0]];
         seg = hex_glyph(nib);
         if (blank_lz && lead && (nib == 4'h0) && (i != NUM_DIGITS - 1)) begin
            seg = 7'h00;
         end
         if (nib != 4'h0) begin
            lead = 1'b0;
         end
         digit_nxt[8*i +: 8] = {dots[i], seg};
      end
   end

   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         digit_out <= '0;
      end else begin
         digit_out <= digit_nxt;
      end
   end

   logic [7:0]     sync1;
   logic [7:0]     sync2;
   logic [DBW-1:0] db_cnt [8];

   // A key's counter only runs while its synchronised level disagrees with the accepted level.
   always_ff @(posedge clk_1MHz) begin
      if (rst) begin
         sync1        <= '0;
         sync2        <= '0;
         key_state    <= '0;
         key_pressed  <= '0;
         key_released <= '0;
         for (int k = 0; k < 8; k++) begin
            db_cnt[k] <= '0;
         end
      end else begin
         sync1        <= raw_keys;
         sync2        <= sync1;
         key_pressed  <= '0;
         key_released <= '0;
         for (int k = 0; k < 8; k++) begin
            if (sync2[k] == key_state[k]) begin
               db_cnt[k] <= '0;
            end else if (db_cnt[k] == DB_LAST) begin
               db_cnt[k]       <= '0;
               key_state[k]    <= sync2[k];
               key_pressed[k]  <= sync2[k];
               key_released[k] <= ~sync2[k];
            end else begin
               db_cnt[k] <= db_cnt[k] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_tm1638_scroll_display.sv
// Directed bench for tm1638_scroll_display: expectations queued at stimulus time, popped and checked when due.
module tb_tm1638_scroll_display;

   localparam int ND = 8;
   localparam int MN = 16;
   localparam int SD = 4;
   localparam int DB = 8;
`ifdef TM1638_SCROLL_KEYCTL_EN
   localparam bit KEYCTL = 1'b1;
`else
   localparam bit KEYCTL = 1'b0;
`endif

   localparam int S_DIG = 0;
   localparam int S_WP  = 1;
   localparam int S_KS  = 2;
   localparam int S_KP  = 3;
   localparam int S_KR  = 4;

   logic          clk_1MHz = 1'b0;
   logic          rst;
   logic [63:0]   msg_value;
   logic          msg_load;
   logic          scroll_en;
   logic          blank_lz;
   logic [ND-1:0] dots;
   logic [7:0]    raw_keys;
   logic [63:0]   digit_out;
   logic [3:0]    window_pos;
   logic [7:0]    key_state;
   logic [7:0]    key_pressed;
   logic [7:0]    key_released;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       tag;
      int          sig;
      logic [63:0] exp;
   } exp_t;

   exp_t sb[$];

   tm1638_scroll_display #(
      .NUM_DIGITS(ND), .MSG_NIBBLES(MN), .SCROLL_DIV(SD), .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk_1MHz(clk_1MHz), .rst(rst), .msg_value(msg_value), .msg_load(msg_load),
      .scroll_en(scroll_en), .blank_lz(blank_lz), .dots(dots), .raw_keys(raw_keys),
      .digit_out(digit_out), .window_pos(window_pos), .key_state(key_state),
      .key_pressed(key_pressed), .key_released(key_released)
   );

   always #5 clk_1MHz = ~clk_1MHz;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
      endcase
   endfunction

   // Rotate the message so the window start is at the top, then read 8 nibbles left to right.
   function automatic logic [63:0] model(input logic [63:0] msg, input int wpos,
                                         input logic [7:0] dts, input logic blank);
      logic [127:0] dbl;
      logic [31:0]  win;
      logic [63:0]  r;
      logic [3:0]   n;
      logic [6:0]   s;
      bit           lead;
      dbl  = {msg, msg} << (4 * wpos);
      win  = dbl[127:96];
      r    = '0;
      lead = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n = win[31-4*i -: 4];
         s = glyph(n);
         if (blank && lead && n == 4'h0 && i < 7) s = 7'h00;
         if (n != 4'h0) lead = 1'b0;
         r[8*i +: 8] = {dts[i], s};
      end
      return r;
   endfunction

   function automatic logic [63:0] observe(input int sig);
      case (sig)
         S_DIG:   observe = digit_out;
         S_WP:    observe = {60'h0, window_pos};
         S_KS:    observe = {56'h0, key_state};
         S_KP:    observe = {56'h0, key_pressed};
         default: observe = {56'h0, key_released};
      endcase
   endfunction

   task automatic push(input string tag, input int sig, input logic [63:0] e);
      sb.push_back('{tag: tag, sig: sig, exp: e});
   endtask

   task automatic drain();
      exp_t        e;
      logic [63:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sig);
         n_vec++;
         assert (obs === e.exp)
         else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_1MHz);
         #1;
      end
   endtask

   task automatic press(input logic [7:0] k, input logic [3:0] wp_exp, input string tag);
      raw_keys = k;
      tick(11);
      push(tag, S_WP, {60'h0, wp_exp});
      drain();
      raw_keys = 8'h00;
      tick(12);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; msg_value = '0; msg_load = 1'b0; scroll_en = 1'b0;
      blank_lz = 1'b0; dots = '0; raw_keys = '0;
      tick(2);
      push("rst_dig", S_DIG, 64'h0); push("rst_wp", S_WP, 64'h0);
      push("rst_ks", S_KS, 64'h0);   push("rst_kp", S_KP, 64'h0);
      push("rst_kr", S_KR, 64'h0);
      drain();

      // plain load, no scroll
      rst = 1'b0;
      msg_value = 64'h0123456789ABCDEF; msg_load = 1'b1;
      tick(1);
      msg_load = 1'b0;
      push("load_wp", S_WP, 64'h0);
      drain();
      tick(1);
      push("t1_dig", S_DIG, 64'h077D6D664F5B063F);
      push("t1_model", S_DIG, model(msg_value, 0, 8'h00, 1'b0));
      drain();
      tick(10);
      push("hold_wp", S_WP, 64'h0);
      drain();

      // auto-scroll: one step every SD cycles
      scroll_en = 1'b1;
      for (int s = 0; s < 9; s++) begin
         tick(3);
         push("scr_mid", S_WP, 64'(s));
         drain();
         tick(1);
         push("scr_step", S_WP, 64'(s + 1));
         drain();
      end
      scroll_en = 1'b0;
      tick(1);
      push("t2_wp", S_WP, 64'd9);
      push("t2_dig", S_DIG, 64'h3F71795E397C776F);
      push("t2_model", S_DIG, model(msg_value, 9, 8'h00, 1'b0));
      drain();

      // pause keeps the prescaler value
      scroll_en = 1'b1;
      tick(2);
      scroll_en = 1'b0;
      tick(5);
      push("pause_wp", S_WP, 64'd9);
      drain();
      scroll_en = 1'b1;
      tick(1);
      push("resume_wp_a", S_WP, 64'd9);
      drain();
      tick(1);
      push("resume_wp_b", S_WP, 64'd10);
      drain();
      scroll_en = 1'b0;

      // leading-zero blanking and dots
      msg_value = 64'h0000000000000012; msg_load = 1'b1;
      tick(1);
      msg_load = 1'b0; blank_lz = 1'b1;
      tick(1);
      push("t3_blank", S_DIG, 64'h3F00000000000000);
      push("t3_model", S_DIG, model(msg_value, 0, 8'h00, 1'b1));
      drain();
      dots = 8'h01;
      tick(1);
      push("t3_dot", S_DIG, 64'h3F00000000000080);
      drain();
      blank_lz = 1'b0;
      tick(1);
      push("t3_noblank", S_DIG, 64'h3F3F3F3F3F3F3FBF);
      drain();
      blank_lz = 1'b1; scroll_en = 1'b1;
      tick(48);
      scroll_en = 1'b0;
      tick(1);
      push("t3_wp12", S_WP, 64'd12);
      push("t3_mid", S_DIG, 64'h3F3F3F3F5B060080);
      push("t3_mid_model", S_DIG, model(msg_value, 12, 8'h01, 1'b1));
      drain();
      dots = 8'h00; blank_lz = 1'b0;

      // glitch shorter than the debounce window is ignored
      raw_keys = 8'h08;
      for (int t = 0; t < 5; t++) begin
         tick(1);
         push("glitch_kp", S_KP, 64'h0);
         drain();
      end
      raw_keys = 8'h00;
      for (int t = 0; t < 15; t++) begin
         tick(1);
         push("glitch_kp2", S_KP, 64'h0);
         push("glitch_ks", S_KS, 64'h0);
         drain();
      end

      // press and release latency
      raw_keys = 8'h08;
      for (int t = 1; t <= 12; t++) begin
         tick(1);
         push("press_kp", S_KP, (t == 10) ? 64'h08 : 64'h0);
         push("press_ks", S_KS, (t >= 10) ? 64'h08 : 64'h0);
         drain();
      end
      raw_keys = 8'h00;
      for (int t = 1; t <= 12; t++) begin
         tick(1);
         push("rel_kr", S_KR, (t == 10) ? 64'h08 : 64'h0);
         push("rel_ks", S_KS, (t >= 10) ? 64'h0 : 64'h08);
         drain();
      end

      // simultaneous keys reported together
      raw_keys = 8'h05;
      tick(10);
      push("multi_kp", S_KP, 64'h05);
      push("multi_ks", S_KS, 64'h05);
      drain();
      tick(1);
      push("multi_kp_off", S_KP, 64'h0);
      push("multi_wp", S_WP, KEYCTL ? 64'd13 : 64'd12);
      drain();

      // load on the scroll terminal count
      msg_value = 64'h0123456789ABCDEF; msg_load = 1'b1;
      tick(1);
      msg_load = 1'b0; scroll_en = 1'b1;
      tick(7);
      push("tc_pre_wp", S_WP, 64'd1);
      drain();
      msg_load = 1'b1;
      tick(1);
      msg_load = 1'b0;
      push("tc_load_wp", S_WP, 64'd0);
      drain();
      tick(3);
      push("tc_ps_clr", S_WP, 64'd0);
      drain();
      tick(1);
      push("tc_ps_step", S_WP, 64'd1);
      drain();

      // reset mid-scroll with keys held
      tick(2);
      rst = 1'b1; scroll_en = 1'b0;
      tick(1);
      push("mrst_dig", S_DIG, 64'h0); push("mrst_wp", S_WP, 64'h0);
      push("mrst_ks", S_KS, 64'h0);   push("mrst_kp", S_KP, 64'h0);
      push("mrst_kr", S_KR, 64'h0);
      drain();
      rst = 1'b0; blank_lz = 1'b1; dots = 8'h01;
      tick(1);
      push("mrst_shadow", S_DIG, 64'h3F00000000000080);
      drain();
      for (int t = 2; t <= 11; t++) begin
         tick(1);
         push("mrst_rekp", S_KP, (t == 10) ? 64'h05 : 64'h0);
         drain();
      end
      push("mrst_wp_key", S_WP, KEYCTL ? 64'd1 : 64'd0);
      drain();

      // manual window stepping from keys
      raw_keys = 8'h00;
      tick(12);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      press(8'h02, KEYCTL ? 4'd15 : 4'd0, "kc_dec");
      press(8'h01, KEYCTL ? 4'd0 : 4'd0, "kc_inc1");
      press(8'h01, KEYCTL ? 4'd1 : 4'd0, "kc_inc2");
      press(8'h03, KEYCTL ? 4'd1 : 4'd0, "kc_both");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tm1638_scroll_display.md
Name: tm1638_scroll_display

Overview:
Parametrised front-end for the TM1638 keys/display core. It holds a hex message longer than the physical display and presents a NUM_DIGITS-wide window of it as encoded 7-segment bytes. The window can auto-scroll as a circular rotation, and leading zeros can be blanked. The block also debounces the 8 raw key lines returned by the core and emits press/release events. It sits between application logic and the tm1638_keys_display digit/keys ports.

Parameters:
NUM_DIGITS, 8, displayed digits (1..16).
MSG_NIBBLES, 16, message length in hex nibbles (>= NUM_DIGITS).
SCROLL_DIV, 250000, clk_1MHz cycles per scroll step (>= 2).
DEBOUNCE_CYCLES, 10000, stable cycles required before a key change is accepted (>= 2).

Ports:
clk_1MHz  in  1  system clock.
rst  in  1  synchronous, active-high reset.
msg_value  in  4*MSG_NIBBLES  message; nibble MSG_NIBBLES-1 (MS) is shown leftmost at position 0.
msg_load  in  1  single-cycle pulse; latches msg_value into the shadow register.
scroll_en  in  1  1 = auto-scroll, 0 = hold the current window.
blank_lz  in  1  1 = blank leading zeros in the displayed window.
dots  in  NUM_DIGITS  dots[i] drives the DP of display digit i (i=0 is leftmost).
raw_keys  in  8  asynchronous key levels from the TM1638 core.
digit_out  out  8*NUM_DIGITS  byte i = {dp,g,f,e,d,c,b,a} for display digit i; byte 0 = bits [7:0] = leftmost digit.
window_pos  out  clog2(MSG_NIBBLES) (min 1)  index of the message nibble shown leftmost (0 = MS nibble).
key_state  out  8  debounced key levels.
key_pressed  out  8  1-cycle pulse on a debounced 0->1 transition.
key_released  out  8  1-cycle pulse on a debounced 1->0 transition.

Behaviour:
- Reset (synchronous): shadow=0, window_pos=0, prescaler=0, digit_out=0 (all segments off), key_state=0, key_pressed=0, key_released=0, debounce counters=0, synchroniser flops=0.
- msg_load=1: shadow<=msg_value; window_pos<=0; prescaler<=0. msg_load takes priority over a scroll step in the same cycle.
- Scroll: when scroll_en=1, the prescaler counts 0..SCROLL_DIV-1. At terminal count, window_pos<=(window_pos+1) mod MSG_NIBBLES and the prescaler returns to 0.
- scroll_en=0: prescaler and window_pos hold. Re-asserting scroll_en resumes from the held prescaler value.
- Window: display digit i shows nibble index (window_pos+i) mod MSG_NIBBLES, counted from the MS nibble. Indexing wraps circularly, so the window continues across the end of the message back to its start.
- Encoding: 0-F map to standard hex glyphs (0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71). bit7 = dots[i].
- Leading-zero blank: with blank_lz=1, every zero digit to the left of the first nonzero displayed digit has its segments forced to 0x00. The rightmost digit is never blanked. The DP is unaffected by blanking.
- digit_out is registered. It reflects shadow, window_pos, dots and blank_lz with 1-cycle latency.
- Keys:
  - raw_keys pass through a 2-flop synchroniser.
  - For each key, the counter clears whenever sync==key_state. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, key_state toggles, the matching pressed/released bit pulses for exactly 1 cycle, and the counter clears.
  - Input-to-event latency is 2 + DEBOUNCE_CYCLES cycles. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
  - Keys are independent; simultaneous events on several keys are all reported in the same cycle.
- Reset mid-scroll or mid-debounce aborts the operation and returns every register to its reset value on the next edge.

Optional Feature:
TM1638_SCROLL_KEYCTL_EN:
- Defined: when scroll_en=0, key_pressed[0] steps window_pos +1 (mod MSG_NIBBLES) and key_pressed[1] steps it -1 (mod MSG_NIBBLES, so 0 -> MSG_NIBBLES-1).
  - Both keys in the same cycle: no change.
  - msg_load still has priority over key steps.
  - Keys have no effect on window_pos while scroll_en=1.
- Not defined: window_pos changes only via msg_load and auto-scroll. The key logic does not touch the window.

Test Plan:
1. Reset, then msg_load with msg_value=64'h0123456789ABCDEF, scroll_en=0, blank_lz=0, dots=0 -> after 1 cycle, digit_out bytes 0..7 = 3F,06,5B,4F,66,6D,7D,07 and window_pos=0.
2. Same message, scroll_en=1, SCROLL_DIV=4 -> window_pos increments every 4 cycles. After 9 steps, window_pos=9, byte 0 = 0x6F ('9') and byte 7 = 0x3F (the display wraps back to nibble 0).
3. msg_value=64'h0000000000000012 loaded, scroll_en=0, so the window shows nibbles 0..7 (all zero) -> blank_lz=1 gives all bytes 0x00 except byte 7=0x3F. With dots=8'h01, byte 0=0x80.
4. DEBOUNCE_CYCLES=8; raw_keys[3] pulses high for 5 cycles -> no event. Then raw_keys[3] held high -> key_pressed=8'h08 for exactly 1 cycle, 10 cycles after the rise, and key_state[3]=1. Release -> key_released=8'h08.
5. msg_load asserted on the same cycle as a scroll terminal count -> window_pos=0 and prescaler=0. Assert rst mid-scroll -> all outputs return to 0 on the next edge.
6. With TM1638_SCROLL_KEYCTL_EN defined, scroll_en=0 and window_pos=0: debounced press of key1 -> window_pos=15. Then press key0 twice -> window_pos=1. Simultaneous key0+key1 press -> unchanged.
